// File: rtl/gray_stream_encoder.sv
// Streaming binary-to-Gray encoder with a two-entry skid buffer and an internal Gray
// sequence generator. Each output word carries an adjacency flag that compares it with
// the previously transferred word, and a wrap flag marking the last generated code.
module gray_stream_encoder #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_adj,
  output logic             out_wrap
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  // Effective mode; only follows gen_mode while the skid entry is empty
  logic             mode_q;
  logic [WIDTH-1:0] gen_cnt_q;

  // Main output register
  logic             main_valid_q;
  logic [WIDTH-1:0] main_gray_q;
  logic             main_adj_q;
  logic             main_wrap_q;

  // Skid register
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_gray_q;
  logic             skid_wrap_q;

  // Last transferred output word
  logic             hist_valid_q;
  logic [WIDTH-1:0] last_gray_q;

  logic             src_valid;
  logic [WIDTH-1:0] src_bin;
  logic [WIDTH-1:0] new_gray;
  logic             new_wrap;
  logic             accept;
  logic             out_xfer;
  logic             load_main;
  logic             load_skid;
  logic             hist_valid_nxt;
  logic [WIDTH-1:0] hist_gray_nxt;
  logic [WIDTH-1:0] main_gray_d;
  logic             main_wrap_d;
  logic [WIDTH-1:0] diff;
  logic             main_adj_d;

  // Source selection, handshake decode and next main-register contents
  always_comb begin
    src_valid = mode_q | in_valid;
    src_bin   = mode_q ? gen_cnt_q : in_bin;
    new_gray  = src_bin ^ (src_bin >> 1);
    new_wrap  = mode_q & (&src_bin);
    accept    = src_valid & ~skid_valid_q;
    out_xfer  = main_valid_q & out_ready;

    // A skid entry refills main on transfer; otherwise a new word loads when main frees up
    load_main = skid_valid_q ? out_xfer : (accept & (~main_valid_q | out_xfer));
    load_skid = accept & main_valid_q & ~out_xfer;

    main_gray_d = skid_valid_q ? skid_gray_q : new_gray;
    main_wrap_d = skid_valid_q ? skid_wrap_q : new_wrap;

    // Adjacency is judged against the history as it stands once this cycle's transfer lands
    hist_valid_nxt = hist_valid_q | out_xfer;
    hist_gray_nxt  = out_xfer ? main_gray_q : last_gray_q;
    diff           = main_gray_d ^ hist_gray_nxt;
    main_adj_d     = hist_valid_nxt & (diff != '0) & ((diff & (diff - One)) == '0);
  end

  // Main output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_gray_q  <= '0;
      main_adj_q   <= 1'b0;
      main_wrap_q  <= 1'b0;
    end else if (load_main) begin
      main_valid_q <= 1'b1;
      main_gray_q  <= main_gray_d;
      main_adj_q   <= main_adj_d;
      main_wrap_q  <= main_wrap_d;
    end else if (out_xfer) begin
      main_valid_q <= 1'b0;
    end
  end

  // Skid register: catches a word accepted while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_gray_q  <= '0;
      skid_wrap_q  <= 1'b0;
    end else if (load_skid) begin
      skid_valid_q <= 1'b1;
      skid_gray_q  <= new_gray;
      skid_wrap_q  <= new_wrap;
    end else if (skid_valid_q && out_xfer) begin
      skid_valid_q <= 1'b0;
    end
  end

  // History of the last transferred word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid_q <= 1'b0;
      last_gray_q  <= '0;
    end else if (out_xfer) begin
      hist_valid_q <= 1'b1;
      last_gray_q  <= main_gray_q;
    end
  end

  // Generator count and mode tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_cnt_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      if (accept && mode_q) begin
        gen_cnt_q <= gen_cnt_q + One;
      end
      if (!skid_valid_q) begin
        mode_q <= gen_mode;
      end
    end
  end

  // Outputs are all register-driven
  always_comb begin
    in_ready  = ~skid_valid_q & ~mode_q;
    out_valid = main_valid_q;
    out_gray  = main_gray_q;
    out_adj   = main_adj_q;
    out_wrap  = main_wrap_q;
  end

endmodule

// File: tb/tb_gray_stream_encoder.sv
// Bench for gray_stream_encoder: directed and random stimulus against a queue-based
// reference model of the stream, the generator sequence and the adjacency history.
module tb_gray_stream_encoder;

  localparam int W = 3;
  localparam int N = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         gen_mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gray;
  logic         out_adj;
  logic         out_wrap;

  gray_stream_encoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gen_mode  (gen_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_adj   (out_adj),
    .out_wrap  (out_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int q[$];       // expected Gray words in buffer order (encode mode)
  bit hist_v;
  int last;
  int gen_cnt;
  bit phase_gen;
  bit acc;
  int xfers;

  int vectors;
  int miscompares;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) % N;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample/compare at the falling edge, then advance past the rising edge
  task automatic cycle();
    int exp_g;
    int exp_w;
    int exp_a;
    @(negedge clk);
    acc = 1'b0;
    if (!phase_gen) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
    end
    if (out_valid) begin
      if (phase_gen) begin
        exp_g = gray_of(gen_cnt);
        exp_w = (gen_cnt == N - 1) ? 1 : 0;
      end else begin
        exp_g = (q.size() != 0) ? q[0] : -1;
        exp_w = 0;
      end
      exp_a = (hist_v && $countones(exp_g ^ last) == 1) ? 1 : 0;
      chk("out_gray", {29'd0, out_gray}, exp_g);
      chk("out_adj", {31'd0, out_adj}, exp_a);
      chk("out_wrap", {31'd0, out_wrap}, exp_w);
      if (out_ready) begin
        hist_v = 1'b1;
        last   = exp_g;
        xfers++;
        if (phase_gen) gen_cnt = (gen_cnt + 1) % N;
        else if (q.size() != 0) void'(q.pop_front());
      end
    end
    if (!phase_gen && in_valid && in_ready) begin
      q.push_back(gray_of(int'(in_bin)));
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int b);
    int i;
    in_valid = 1'b1;
    in_bin   = b[W-1:0];
    i = 0;
    do begin
      cycle();
      i++;
    end while (!acc && i < 20);
    chk("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (out_valid || q.size() != 0); i++) cycle();
    chk("drained", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic enter_gen();
    drain();
    gen_mode  = 1'b1;
    phase_gen = 1'b1;
  endtask

  task automatic leave_gen();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    gen_mode  = 1'b0;
    for (int i = 0; i < 10 && out_valid; i++) cycle();
    chk("gen_drained", {31'd0, out_valid}, 32'd0);
    phase_gen = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_gray", {29'd0, out_gray}, 32'd0);
    chk("rst_out_adj", {31'd0, out_adj}, 32'd0);
    chk("rst_out_wrap", {31'd0, out_wrap}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pairs[6];
    int start;
    vectors     = 0;
    miscompares = 0;
    hist_v      = 1'b0;
    last        = 0;
    gen_cnt     = 0;
    phase_gen   = 1'b0;
    xfers       = 0;
    rst_n       = 1'b0;
    gen_mode    = 1'b0;
    in_valid    = 1'b0;
    in_bin      = '0;
    out_ready   = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 5 then 4: 111 then 110, second one adjacent
    send(5);
    chk("t1_first_gray", {29'd0, out_gray}, 32'd7);
    chk("t1_first_adj", {31'd0, out_adj}, 32'd0);
    send(4);
    chk("t1_second_gray", {29'd0, out_gray}, 32'd6);
    chk("t1_second_adj", {31'd0, out_adj}, 32'd1);
    drain();

    // Back-to-back 0..7
    for (int b = 0; b < N; b++) send(b);
    drain();

    // Backpressure: 2, 3, 6 with a stall after the first output
    send(2);
    out_ready = 1'b0;
    send(3);
    in_bin = 3'd6;
    cycle();
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_gray", {29'd0, out_gray}, 32'd3);
    cycle();
    chk("bp_hold_gray2", {29'd0, out_gray}, 32'd3);
    out_ready = 1'b1;
    send(6);
    drain();

    // Adjacency pairs
    pairs = '{0, 3, 1, 2, 0, 2};
    for (int p = 0; p < 3; p++) begin
      send(pairs[2*p]);
      send(pairs[2*p+1]);
      drain();
    end

    // Generator: ten words with free-flowing output
    enter_gen();
    start = xfers;
    for (int i = 0; i < 40 && (xfers - start) < 10; i++) cycle();
    chk("gen_ten_words", xfers - start, 32'd10);
    leave_gen();

    // Random encode traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 2) == 0;
      in_bin    = W'($urandom);
      out_ready = ($urandom % 4) != 0;
      cycle();
    end
    drain();

    // Random generator traffic with backpressure
    enter_gen();
    for (int i = 0; i < 120; i++) begin
      out_ready = ($urandom % 3) != 0;
      cycle();
    end
    leave_gen();

    // Asynchronous reset with a full skid, then restart
    out_ready = 1'b0;
    send(1);
    send(6);
    chk("pre_rst_skid_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    q.delete();
    hist_v  = 1'b0;
    last    = 0;
    gen_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3);
    chk("post_rst_adj", {31'd0, out_adj}, 32'd0);
    drain();
    enter_gen();
    start = xfers;
    for (int i = 0; i < 20 && (xfers - start) < 6; i++) cycle();
    chk("post_rst_gen_words", xfers - start, 32'd6);
    leave_gen();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_stream_encoder.md
Name: gray_stream_encoder

Overview:
- Streaming binary-to-Gray encoder; the transmit-side counterpart of the team's Gray-to-binary decoder.
- Accepts binary words over a valid/ready handshake and emits registered Gray words over a valid/ready handshake.
- A two-entry skid buffer gives full throughput under backpressure.
- Also provides an internal Gray sequence generator mode and a per-word adjacency flag used to verify single-bit transitions downstream.

Parameters:
WIDTH, 3, bit width of binary input and Gray output (minimum 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
gen_mode  input  1  0 = encode input stream, 1 = internal Gray sequence generator
in_valid  input  1  in_bin holds a word
in_ready  output  1  block can accept a word this cycle
in_bin  input  WIDTH  binary word
out_valid  output  1  out_gray holds a word
out_ready  input  1  downstream accepts the word this cycle
out_gray  output  WIDTH  Gray word
out_adj  output  1  out_gray differs in exactly one bit from the previously transferred output word
out_wrap  output  1  in generator mode, this word is the last Gray code of the sequence (binary all-ones)

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_gray=0, out_adj=0, out_wrap=0, in_ready=1, skid empty, history-valid=0, generator binary count=0.
- Encoding: gray = bin ^ (bin >> 1), logical shift, WIDTH bits, no truncation issues.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency: a word accepted in cycle N appears on out_gray in cycle N+1 when the output register is empty or transferring in cycle N.
- Skid buffer: main output register plus one skid register.
  - in_ready = skid empty (registered; it does not depend combinationally on out_ready).
  - If the input is accepted while the main register is held (out_valid & !out_ready), the encoded word goes to the skid register.
  - On the next output transfer, skid moves to main.
  - No word is dropped or duplicated. Order is preserved.
- Stall: while out_valid & !out_ready, out_gray, out_adj and out_wrap are held stable.
- Simultaneous accept and transfer with skid empty: main loads the new word directly; out_valid stays 1.
- Generator mode (gen_mode=1):
  - in_valid is ignored and in_ready=0.
  - The block internally offers words with binary count 0,1,..,2^WIDTH-1, then wraps to 0.
  - The count increments only when a generated word enters the buffer.
  - out_wrap=1 on the word whose binary source is all-ones.
- gen_mode change: takes effect only when the skid register is empty. Words already buffered drain unchanged. The generator count is not reset by a mode change.
- Adjacency:
  - History register last_gray and history-valid update on every output transfer.
  - out_adj = history-valid & (popcount(out_gray ^ last_gray) == 1).
  - out_adj is computed from the history at the time the word is presented. The first word after reset has out_adj=0.
- out_wrap is 0 in encode mode.
- Reset mid-operation clears both buffer entries, the history and the generator count immediately. The first word after reset behaves as the first word ever.

Test Plan:
- Encode mode, out_ready=1, in_bin=5 then 4: out_gray=3'b111 then 3'b110 one cycle after each accept; out_adj=0 then 1.
- Encode 0..7 back-to-back with out_ready=1: out_gray sequence 000,001,011,010,110,111,101,100. One word per cycle, in_ready always 1. out_adj=0 on the first word, 1 thereafter.
- Backpressure: stream 2,3,6; hold out_ready=0 for 3 cycles after the first output. Required response:
  - out_gray holds 011; the second word is captured in skid; in_ready drops to 0.
  - On release, outputs are 011, 010, 101 in order with none lost.
- Non-adjacent stream 0 then 3: out_gray 000 then 010; out_adj=0 then 1. Stream 1 then 2: outputs 001, 011; out_adj on the second word=1. Stream 0 then 2: outputs 000, 011; second out_adj=0.
- Generator mode, out_ready=1, 10 words: outputs 000,001,011,010,110,111,101,100,000,001. out_wrap=1 only on 100. out_adj=1 on every word after the first, including the 100->000 wrap.
- Assert rst_n=0 mid-stream with a full skid: all outputs return to reset values asynchronously; in_ready=1. The next word has out_adj=0 and the generator restarts at 000.
